// File: rtl/ge_pkg.sv
// Shared constants for the GE game pipeline stages.
package ge_pkg;
    localparam int GRADE_W = 3;
    localparam int BONUS_W = 2;
    localparam int SCORE_W = 5;
    localparam logic [GRADE_W-1:0] PERFECT_GRADE = 3'd7;
    localparam int PASS_TH_DEF = 14;
endpackage

// File: rtl/ge_stage3_eval.sv
// Stage-3 combinational score and rule evaluation.
module ge_stage3_eval
    import ge_pkg::*;
#(
    parameter int PASS_TH = PASS_TH_DEF
) (
    input  logic [GRADE_W-1:0] slide,
    input  logic [GRADE_W-1:0] timing,
    input  logic [GRADE_W-1:0] luck3,
    input  logic [BONUS_W-1:0] bonus2,
    input  logic               pass2,
    output logic               pass3
);

    localparam logic [SCORE_W-1:0] TH = SCORE_W'(PASS_TH);

    logic [SCORE_W-1:0] score;

    // Full-width sum: 7+7+7+6 = 27 fits in 5 bits.
    assign score = {2'b00, slide} + {2'b00, timing}
                 + {2'b00, luck3} + {2'b00, bonus2, 1'b0};

    always_comb begin
        pass3 = 1'b0;
        if (!pass2) begin
            pass3 = 1'b0;
        end else if (timing == '0) begin
            pass3 = 1'b0;
        end else if (slide == PERFECT_GRADE &&
                     timing == PERFECT_GRADE) begin
            pass3 = 1'b1;
        end else begin
            pass3 = (score >= TH);
        end
    end

endmodule

// File: rtl/ge_stage3.sv
// Stage-3 evaluator top: verdict, registered copy and pass counter.
module ge_stage3
    import ge_pkg::*;
#(
    parameter int PASS_TH = PASS_TH_DEF,
    parameter int CNT_W   = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [GRADE_W-1:0] slide,
    input  logic [GRADE_W-1:0] timing,
    input  logic [GRADE_W-1:0] luck3,
    input  logic [BONUS_W-1:0] bonus2,
    input  logic               pass2,
    output logic               pass3,
    output logic               pass3_q,
    output logic [CNT_W-1:0]   pass_cnt
);

    ge_stage3_eval #(
        .PASS_TH(PASS_TH)
    ) u_eval (
        .slide (slide),
        .timing(timing),
        .luck3 (luck3),
        .bonus2(bonus2),
        .pass2 (pass2),
        .pass3 (pass3)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass3_q  <= 1'b0;
            pass_cnt <= '0;
        end else begin
            pass3_q <= pass3;
            // Saturate instead of wrapping.
            if (pass3 && pass_cnt != '1) begin
                pass_cnt <= pass_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ge_stage3.sv
// Self-checking bench for ge_stage3.
module tb_ge_stage3;

    logic        clk;
    logic        rst;
    logic [2:0]  slide;
    logic [2:0]  timing;
    logic [2:0]  luck3;
    logic [1:0]  bonus2;
    logic        pass2;
    logic        pass3;
    logic        pass3_q;
    logic [11:0] pass_cnt;
    logic        pass3_s;
    logic        pass3_q_s;
    logic [2:0]  pass_cnt_s;

    int errors = 0;
    int checks = 0;

    ge_stage3 #(.PASS_TH(14), .CNT_W(12)) dut (
        .clk     (clk),
        .rst     (rst),
        .slide   (slide),
        .timing  (timing),
        .luck3   (luck3),
        .bonus2  (bonus2),
        .pass2   (pass2),
        .pass3   (pass3),
        .pass3_q (pass3_q),
        .pass_cnt(pass_cnt)
    );

    ge_stage3 #(.PASS_TH(14), .CNT_W(3)) dut3 (
        .clk     (clk),
        .rst     (rst),
        .slide   (slide),
        .timing  (timing),
        .luck3   (luck3),
        .bonus2  (bonus2),
        .pass2   (pass2),
        .pass3   (pass3_s),
        .pass3_q (pass3_q_s),
        .pass_cnt(pass_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int s;
        int t;
        int l;
        int b;
        int p;
        int exp;
    } vec_t;

    function automatic int ref_pass(int s, int t, int l, int b, int p);
        if (p == 0) return 0;
        if (t == 0) return 0;
        if (s == 7 && t == 7) return 1;
        return ((s + t + l + 2 * b) >= 14) ? 1 : 0;
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic apply(int s, int t, int l, int b, int p);
        slide  = 3'(s);
        timing = 3'(t);
        luck3  = 3'(l);
        bonus2 = 2'(b);
        pass2  = 1'(p);
    endtask

    vec_t vecs[8];
    int   m_cnt;
    int   m_cnt3;
    int   m_q;
    int   rs, rt, rl, rb, rp, e;

    initial begin
        vecs[0] = '{7, 7, 7, 3, 0, 0};
        vecs[1] = '{7, 0, 7, 3, 1, 0};
        vecs[2] = '{7, 7, 0, 0, 1, 1};
        vecs[3] = '{4, 4, 4, 1, 1, 1};
        vecs[4] = '{4, 4, 4, 0, 1, 0};
        vecs[5] = '{3, 4, 5, 0, 1, 0};
        vecs[6] = '{7, 6, 0, 0, 1, 0};
        vecs[7] = '{6, 7, 1, 0, 1, 1};

        rst = 1'b1;
        apply(0, 0, 0, 0, 0);
        @(negedge clk);
        check("reset_q", int'(pass3_q), 0);
        check("reset_cnt", int'(pass_cnt), 0);

        // Directed vectors, with reset still asserted.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            apply(vecs[i].s, vecs[i].t, vecs[i].l,
                  vecs[i].b, vecs[i].p);
            #2;
            check($sformatf("vec%0d", i), int'(pass3), vecs[i].exp);
        end

        // Exhaustive sweep under reset.
        for (int i = 0; i < 4096; i++) begin
            @(negedge clk);
            rs = (i >> 9) & 7;
            rt = (i >> 6) & 7;
            rl = (i >> 3) & 7;
            rb = (i >> 1) & 3;
            rp = i & 1;
            apply(rs, rt, rl, rb, rp);
            #2;
            e = ref_pass(rs, rt, rl, rb, rp);
            if (int'(pass3) != e) begin
                check($sformatf("exh%0d", i), int'(pass3), e);
            end else begin
                checks++;
            end
        end
        check("rst_hold_cnt", int'(pass_cnt), 0);
        check("rst_hold_q", int'(pass3_q), 0);

        // Hold a pass for 5 clocks.
        @(negedge clk);
        apply(4, 4, 4, 1, 1);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("cnt5", int'(pass_cnt), 5);
        check("cnt5_q", int'(pass3_q), 1);
        check("cnt5_small", int'(pass_cnt_s), 5);

        // Mid-cycle asynchronous reset.
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_cnt", int'(pass_cnt), 0);
        check("async_q", int'(pass3_q), 0);
        check("async_small", int'(pass_cnt_s), 0);
        check("async_pass3", int'(pass3), 1);

        // Saturation of the narrow counter.
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("sat_small", int'(pass_cnt_s), 7);
        check("sat_wide", int'(pass_cnt), 10);
        check("sat_q", int'(pass3_q), 1);

        // Random stimulus against the behavioural model.
        m_cnt  = 10;
        m_cnt3 = 7;
        m_q    = 1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            rs = int'($urandom_range(7));
            rt = int'($urandom_range(7));
            rl = int'($urandom_range(7));
            rb = int'($urandom_range(3));
            rp = int'($urandom_range(1));
            apply(rs, rt, rl, rb, rp);
            #1;
            e = ref_pass(rs, rt, rl, rb, rp);
            check("rnd_pass3", int'(pass3), e);
            @(posedge clk);
            if (e == 1) begin
                if (m_cnt < 4095) m_cnt++;
                if (m_cnt3 < 7) m_cnt3++;
            end
            m_q = e;
            #1;
            check("rnd_q", int'(pass3_q), m_q);
            check("rnd_cnt", int'(pass_cnt), m_cnt);
            check("rnd_small", int'(pass_cnt_s), m_cnt3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
